// File: rtl/mem_access.sv
// MEM-stage load/store unit: runs one req/ack data-memory transaction per memory op, stalls the
// front of the pipeline until it completes. Optional alignment trap via MEM_ALIGN_CHECK_EN.
module mem_access #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid_in,
    input  logic        i_memread,
    input  logic        i_memwrite,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned_ld,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata_in,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [3:0]  o_dmem_be,
    output logic [31:0] o_dmem_wdata,
    input  logic [31:0] i_dmem_rdata,
    input  logic        i_dmem_ack,
    output logic        o_stall,
    output logic [31:0] o_load_data,
    output logic        o_exc_align,
    output logic        o_exc_bus
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    localparam logic [8:0] MaxWait = 9'(MAX_WAIT);

    state_e      r_state, w_state_next;
    logic [7:0]  r_cnt;
    logic        r_req, r_we, r_unsigned, r_exc_bus;
    logic [31:0] r_addr, r_wdata, r_load_data;
    logic [3:0]  r_be;
    logic [1:0]  r_size, r_lane;

    logic        w_mem_op, w_misalign, w_access;
    logic        w_start, w_ack_done, w_timeout, w_stall;
    logic [8:0]  w_cnt_inc;
    logic [1:0]  w_lane;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_fmt;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_mem_op = i_valid_in & (i_memread | i_memwrite);

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = w_mem_op & (((i_size == 2'b01) & i_addr[0]) |
                                    (i_size[1] & (i_addr[1:0] != 2'b00)));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_access  = w_mem_op & ~w_misalign;
    assign w_cnt_inc = {1'b0, r_cnt} + 9'd1;

    // Lane select masks offending low bits, so unchecked misaligned ops fall onto a legal lane.
    always_comb begin
        w_lane  = 2'b00;
        w_be    = 4'b1111;
        w_wdata = i_wdata_in;
        case (i_size)
            2'b00: begin
                w_lane  = i_addr[1:0];
                w_be    = 4'b0001 << i_addr[1:0];
                w_wdata = {4{i_wdata_in[7:0]}};
            end
            2'b01: begin
                w_lane  = {i_addr[1], 1'b0};
                w_be    = 4'b0011 << {i_addr[1], 1'b0};
                w_wdata = {2{i_wdata_in[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_byte = i_dmem_rdata[7:0];
        case (r_lane)
            2'd1:    w_byte = i_dmem_rdata[15:8];
            2'd2:    w_byte = i_dmem_rdata[23:16];
            2'd3:    w_byte = i_dmem_rdata[31:24];
            default: w_byte = i_dmem_rdata[7:0];
        endcase
        w_half = r_lane[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
        case (r_size)
            2'b00:   w_fmt = r_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_fmt = r_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_fmt = i_dmem_rdata;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        w_start      = 1'b0;
        w_ack_done   = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_access) begin
                    w_stall      = 1'b1;
                    w_start      = 1'b1;
                    w_state_next = StBusy;
                end
            end
            StBusy: begin
                w_stall = 1'b1;
                if (i_dmem_ack) begin
                    w_ack_done   = 1'b1;
                    w_state_next = StDone;
                end else if (w_cnt_inc == MaxWait) begin
                    w_timeout    = 1'b1;
                    w_state_next = StDone;
                end
            end
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= 8'd0;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_unsigned  <= 1'b0;
            r_exc_bus   <= 1'b0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_load_data <= 32'd0;
            r_be        <= 4'd0;
            r_size      <= 2'd0;
            r_lane      <= 2'd0;
        end else begin
            r_exc_bus <= w_timeout;
            if (w_start) begin
                r_req      <= 1'b1;
                r_we       <= i_memwrite;
                r_addr     <= {i_addr[31:2], 2'b00};
                r_be       <= w_be;
                r_wdata    <= w_wdata;
                r_size     <= i_size;
                r_lane     <= w_lane;
                r_unsigned <= i_unsigned_ld;
                r_cnt      <= 8'd0;
            end
            if (r_state == StBusy) begin
                r_cnt <= w_cnt_inc[7:0];
            end
            if (w_ack_done) begin
                r_req <= 1'b0;
                if (!r_we) begin
                    r_load_data <= w_fmt;
                end
            end
            if (w_timeout) begin
                r_req       <= 1'b0;
                r_load_data <= 32'd0;
            end
        end
    end

    assign o_dmem_req   = r_req;
    assign o_dmem_we    = r_we;
    assign o_dmem_addr  = r_addr;
    assign o_dmem_be    = r_be;
    assign o_dmem_wdata = r_wdata;
    assign o_stall      = w_stall;
    assign o_load_data  = r_load_data;
    assign o_exc_align  = w_misalign;
    assign o_exc_bus    = r_exc_bus;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed test-plan cases plus random ops against an arithmetic model.
// Expectations follow MEM_ALIGN_CHECK_EN when it is defined for the build.
module tb_mem_access;

    localparam int MW = 4;

    logic        clk, rst;
    logic        valid, rd, wr, uns, ack;
    logic [1:0]  sz;
    logic [31:0] addr, wd, rdata;
    logic        o_dmem_req, o_dmem_we, o_stall, o_exc_align, o_exc_bus;
    logic [31:0] o_dmem_addr, o_dmem_wdata, o_load_data;
    logic [3:0]  o_dmem_be;

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] model_ld = 32'd0;

    mem_access #(.MAX_WAIT(MW)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_valid_in   (valid),
        .i_memread    (rd),
        .i_memwrite   (wr),
        .i_size       (sz),
        .i_unsigned_ld(uns),
        .i_addr       (addr),
        .i_wdata_in   (wd),
        .o_dmem_req   (o_dmem_req),
        .o_dmem_we    (o_dmem_we),
        .o_dmem_addr  (o_dmem_addr),
        .o_dmem_be    (o_dmem_be),
        .o_dmem_wdata (o_dmem_wdata),
        .i_dmem_rdata (rdata),
        .i_dmem_ack   (ack),
        .o_stall      (o_stall),
        .o_load_data  (o_load_data),
        .o_exc_align  (o_exc_align),
        .o_exc_bus    (o_exc_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_fmt(logic [31:0] rv, logic [31:0] a, logic [1:0] s,
                                            logic u);
        longint v;
        case (s)
            2'b00: begin
                v = longint'((rv >> (8 * (a % 4))) & 32'hFF);
                if (!u && v >= 128) v = v - 256;
            end
            2'b01: begin
                v = longint'((rv >> (16 * ((a % 4) / 2))) & 32'hFFFF);
                if (!u && v >= 32768) v = v - 65536;
            end
            default: v = longint'(rv);
        endcase
        return v[31:0];
    endfunction

    function automatic logic [3:0] exp_be(logic [31:0] a, logic [1:0] s);
        logic [3:0] b;
        if (s == 2'b00) begin
            b = 4'b0001;
            b = b << (a % 4);
        end else if (s == 2'b01) begin
            b = 4'b0011;
            b = b << (2 * ((a % 4) / 2));
        end else begin
            b = 4'b1111;
        end
        return b;
    endfunction

    function automatic logic [31:0] exp_wd(logic [31:0] d, logic [1:0] s);
        if (s == 2'b00) return {4{d[7:0]}};
        if (s == 2'b01) return {2{d[15:0]}};
        return d;
    endfunction

    function automatic bit is_misaligned(logic [31:0] a, logic [1:0] s);
        return (s == 2'b01 && a[0]) || (s[1] && a[1:0] != 2'b00);
    endfunction

    // lat = BUSY cycle (1-based) carrying the ack; 0 or > MW means no ack (timeout).
    task automatic run_op(input logic r, input logic w, input logic [1:0] s, input logic u,
                          input logic [31:0] a, input logic [31:0] d, input logic [31:0] rv,
                          input int lat);
        int busy;
        bit tmo;
        logic [31:0] exp_ld;
        tmo    = !(lat >= 1 && lat <= MW);
        busy   = tmo ? MW : lat;
        exp_ld = tmo ? 32'd0 : (w ? model_ld : exp_fmt(rv, a, s, u));
        @(negedge clk);
        valid = 1'b1; rd = r; wr = w; sz = s; uns = u; addr = a; wd = d; ack = 1'b0;
        #1;
        chk("c0_stall", 32'(o_stall), 32'd1);
        chk("c0_req", 32'(o_dmem_req), 32'd0);
        chk("c0_align", 32'(o_exc_align), 32'd0);
        for (int n = 1; n <= busy; n++) begin
            @(negedge clk);
            chk("busy_stall", 32'(o_stall), 32'd1);
            chk("busy_req", 32'(o_dmem_req), 32'd1);
            chk("busy_we", 32'(o_dmem_we), 32'(w));
            chk("busy_addr", o_dmem_addr, {a[31:2], 2'b00});
            chk("busy_be", 32'(o_dmem_be), 32'(exp_be(a, s)));
            chk("busy_wdata", o_dmem_wdata, exp_wd(d, s));
            chk("busy_bus", 32'(o_exc_bus), 32'd0);
            ack   = (n == lat);
            rdata = (n == lat) ? rv : $urandom;
        end
        @(negedge clk);
        ack = 1'b0;
        chk("done_stall", 32'(o_stall), 32'd0);
        chk("done_req", 32'(o_dmem_req), 32'd0);
        chk("done_bus", 32'(o_exc_bus), 32'(tmo));
        chk("done_ld", o_load_data, exp_ld);
        @(negedge clk);
        valid = 1'b0; rd = 1'b0; wr = 1'b0;
        #1;
        chk("idle_stall", 32'(o_stall), 32'd0);
        chk("idle_req", 32'(o_dmem_req), 32'd0);
        chk("idle_bus", 32'(o_exc_bus), 32'd0);
        chk("idle_ld", o_load_data, exp_ld);
        model_ld = exp_ld;
    endtask

    task automatic run_misaligned(input logic r, input logic w, input logic [1:0] s,
                                  input logic [31:0] a);
        @(negedge clk);
        valid = 1'b1; rd = r; wr = w; sz = s; addr = a; ack = 1'b0;
        #1;
        chk("mis_align", 32'(o_exc_align), 32'd1);
        chk("mis_stall", 32'(o_stall), 32'd0);
        @(negedge clk);
        chk("mis_req", 32'(o_dmem_req), 32'd0);
        chk("mis_ld", o_load_data, model_ld);
        valid = 1'b0; rd = 1'b0; wr = 1'b0;
        #1;
        chk("mis_clear", 32'(o_exc_align), 32'd0);
    endtask

    initial begin
        int kind, lat;
        logic [1:0] s;
        logic [31:0] a;
        rst = 1'b1; valid = 1'b0; rd = 1'b0; wr = 1'b0; sz = 2'b00; uns = 1'b0;
        addr = 32'd0; wd = 32'd0; rdata = 32'd0; ack = 1'b0;
        #12;
        chk("rst_req", 32'(o_dmem_req), 32'd0);
        chk("rst_we", 32'(o_dmem_we), 32'd0);
        chk("rst_bus", 32'(o_exc_bus), 32'd0);
        chk("rst_be", 32'(o_dmem_be), 32'd0);
        chk("rst_addr", o_dmem_addr, 32'd0);
        chk("rst_wdata", o_dmem_wdata, 32'd0);
        chk("rst_ld", o_load_data, 32'd0);
        chk("rst_stall", 32'(o_stall), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'd0, 32'hDEADBEEF, 1);
        chk("lw_val", o_load_data, 32'hDEADBEEF);
        run_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'd0, 32'h80FF1234, 2);
        chk("lb_val", o_load_data, 32'hFFFFFF80);
        run_op(1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'd0, 32'h80FF1234, 1);
        chk("lbu_val", o_load_data, 32'h00000080);
        run_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000ABCD, 32'h0, 3);
        chk("sh_keeps_ld", o_load_data, 32'h00000080);

        // Timeout, then a stray ack while idle must change nothing.
        run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h200, 32'd0, 32'h12345678, 0);
        @(negedge clk);
        ack = 1'b1; rdata = 32'hCAFEF00D;
        @(negedge clk);
        ack = 1'b0;
        chk("late_req", 32'(o_dmem_req), 32'd0);
        chk("late_stall", 32'(o_stall), 32'd0);
        chk("late_ld", o_load_data, 32'd0);
        chk("late_bus", 32'(o_exc_bus), 32'd0);

`ifdef MEM_ALIGN_CHECK_EN
        run_misaligned(1'b1, 1'b0, 2'b01, 32'h01);
`else
        run_op(1'b1, 1'b0, 2'b01, 1'b0, 32'h01, 32'd0, 32'h4321F00D, 1);
        chk("lh_lane0", o_load_data, 32'hFFFFF00D);
`endif

        // Non-memory op passes straight through.
        @(negedge clk);
        valid = 1'b1; rd = 1'b0; wr = 1'b0; addr = $urandom;
        #1;
        chk("nop_stall", 32'(o_stall), 32'd0);
        @(negedge clk);
        chk("nop_req", 32'(o_dmem_req), 32'd0);
        valid = 1'b0;

        // Reset in the middle of BUSY.
        @(negedge clk);
        valid = 1'b1; rd = 1'b1; wr = 1'b0; sz = 2'b10; addr = 32'h300; ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_req", 32'(o_dmem_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_req", 32'(o_dmem_req), 32'd0);
        @(negedge clk);
        rst = 1'b0; valid = 1'b0; rd = 1'b0;
        #1;
        chk("post_rst_stall", 32'(o_stall), 32'd0);
        @(negedge clk);
        chk("post_rst_req", 32'(o_dmem_req), 32'd0);
        chk("post_rst_bus", 32'(o_exc_bus), 32'd0);
        model_ld = 32'd0;

        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 2);
            s    = 2'($urandom_range(0, 3));
            a    = $urandom;
            lat  = $urandom_range(1, MW + 1);
`ifdef MEM_ALIGN_CHECK_EN
            if (is_misaligned(a, s)) begin
                run_misaligned(kind != 1, kind != 0, s, a);
                continue;
            end
`endif
            run_op(kind != 1, kind != 0, s, 1'($urandom_range(0, 1)), a, $urandom, $urandom,
                   (lat > MW) ? 0 : lat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1);
    end

endmodule
